// File: rtl/power_emu_pkg.sv
// Shared constants for the power emulator CSR block: register map, CTRL/STATUS
// bit positions and the run-controller state encoding.
package power_emu_pkg;

    localparam int unsigned ADDR_CTRL          = 0;
    localparam int unsigned ADDR_STATUS        = 1;
    localparam int unsigned ADDR_TIMEOUT_LIMIT = 2;
    localparam int unsigned ADDR_CYCLE_COUNT   = 3;
    localparam int unsigned ADDR_RESULT_BASE   = 4;

    localparam int CTRL_START  = 0;
    localparam int CTRL_ABORT  = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_TIMEOUT = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/power_emu_run_ctrl.sv
// Run controller: IDLE/RUN sequencing, saturating cycle counter and timeout.
//   state   | meaning
//   ST_IDLE | waiting for START
//   ST_RUN  | core running; ends on core_done, timeout or ABORT
module power_emu_run_ctrl
    import power_emu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        core_done,
    input  logic [31:0] timeout_limit,
    output logic        busy,
    output logic        core_start,
    output logic [31:0] cycle_count,
    output logic        done_evt,
    output logic        timeout_evt
);

    run_state_t  state, state_nxt;
    logic [31:0] count_nxt;
    logic        start_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cycle_count <= '0;
            core_start  <= 1'b0;
        end else begin
            state       <= state_nxt;
            cycle_count <= count_nxt;
            core_start  <= start_nxt;
        end
    end

    // core_done outranks timeout, which outranks ABORT
    always_comb begin
        state_nxt   = state;
        count_nxt   = cycle_count;
        start_nxt   = 1'b0;
        done_evt    = 1'b0;
        timeout_evt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                    count_nxt = '0;
                    start_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                count_nxt = sat_inc(cycle_count);
                if (core_done) begin
                    done_evt  = 1'b1;
                    state_nxt = ST_IDLE;
                end else if ((timeout_limit != '0) && (count_nxt >= timeout_limit)) begin
                    timeout_evt = 1'b1;
                    state_nxt   = ST_IDLE;
                end else if (abort) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);

endmodule

// File: rtl/power_emu_csr.sv
// CSR front end for the power emulator core: register decode, sticky flags,
// result snapshots and irq. Optional timeout enabled by POWER_EMU_TIMEOUT_EN.
module power_emu_csr
    import power_emu_pkg::*;
#(
    parameter int N_CH   = 2,
    parameter int RES_W  = 36,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_read,
    input  logic                  s_write,
    input  logic [ADDR_W-1:0]     s_addr,
    input  logic [31:0]           s_wdata,
    output logic [31:0]           s_rdata,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [N_CH*RES_W-1:0] core_result,
    output logic                  irq
);

    logic             wr_ctrl, wr_status;
    logic             irq_en, done_flag, timeout_flag;
    logic             irq_en_nxt, done_nxt, timeout_nxt;
    logic             busy, done_evt, timeout_evt;
    logic [31:0]      cycle_count, timeout_limit, rd_mux;
    logic [RES_W-1:0] snap [N_CH];

    assign wr_ctrl   = s_write && (s_addr == ADDR_W'(ADDR_CTRL));
    assign wr_status = s_write && (s_addr == ADDR_W'(ADDR_STATUS));

`ifdef POWER_EMU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            timeout_limit <= '0;
        else if (s_write && (s_addr == ADDR_W'(ADDR_TIMEOUT_LIMIT)))
            timeout_limit <= s_wdata;
    end
`else
    // A zero limit disables the timeout path, so STATUS.TIMEOUT stays 0
    assign timeout_limit = '0;
`endif

    power_emu_run_ctrl u_run_ctrl (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (wr_ctrl && s_wdata[CTRL_START]),
        .abort         (wr_ctrl && s_wdata[CTRL_ABORT]),
        .core_done     (core_done),
        .timeout_limit (timeout_limit),
        .busy          (busy),
        .core_start    (core_start),
        .cycle_count   (cycle_count),
        .done_evt      (done_evt),
        .timeout_evt   (timeout_evt)
    );

    // Set events win over a coincident write-1-to-clear
    always_comb begin
        irq_en_nxt  = wr_ctrl ? s_wdata[CTRL_IRQ_EN] : irq_en;
        done_nxt    = done_evt |
                      (done_flag & ~(wr_status & s_wdata[STAT_DONE]));
        timeout_nxt = timeout_evt |
                      (timeout_flag & ~(wr_status & s_wdata[STAT_TIMEOUT]));
    end

    always_comb begin
        rd_mux = '0;
        if (s_addr == ADDR_W'(ADDR_CTRL))
            rd_mux[CTRL_IRQ_EN] = irq_en;
        if (s_addr == ADDR_W'(ADDR_STATUS))
            rd_mux[2:0] = {timeout_flag, done_flag, busy};
        if (s_addr == ADDR_W'(ADDR_TIMEOUT_LIMIT))
            rd_mux = timeout_limit;
        if (s_addr == ADDR_W'(ADDR_CYCLE_COUNT))
            rd_mux = cycle_count;
        for (int k = 0; k < N_CH; k++) begin
            if (s_addr == ADDR_W'(ADDR_RESULT_BASE + 2 * k))
                rd_mux = snap[k][31:0];
            if (s_addr == ADDR_W'(ADDR_RESULT_BASE + 2 * k + 1))
                rd_mux = 32'(snap[k][RES_W-1:32]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irq_en       <= 1'b0;
            done_flag    <= 1'b0;
            timeout_flag <= 1'b0;
            irq          <= 1'b0;
            s_rdata      <= '0;
            for (int k = 0; k < N_CH; k++)
                snap[k] <= '0;
        end else begin
            irq_en       <= irq_en_nxt;
            done_flag    <= done_nxt;
            timeout_flag <= timeout_nxt;
            irq          <= irq_en_nxt & (done_nxt | timeout_nxt);
            if (s_read)
                s_rdata <= rd_mux;
            if (done_evt)
                for (int k = 0; k < N_CH; k++)
                    snap[k] <= core_result[k*RES_W +: RES_W];
        end
    end

endmodule

// File: tb/tb_power_emu_csr.sv
// Directed self-checking bench for power_emu_csr (default N_CH=2, RES_W=36).
module tb_power_emu_csr;

    localparam logic [3:0] A_CTRL = 4'd0, A_STAT = 4'd1, A_LIM = 4'd2, A_CNT = 4'd3;
    localparam logic [3:0] A_LO0 = 4'd4, A_HI0 = 4'd5, A_LO1 = 4'd6, A_HI1 = 4'd7;

    logic        clk = 1'b0;
    logic        reset_n, s_read, s_write, core_done;
    logic [3:0]  s_addr;
    logic [31:0] s_wdata, s_rdata, v, held;
    logic        core_start, irq;
    logic [71:0] core_result;
    int          checks = 0, failures = 0, start_cnt = 0, base;

    power_emu_csr dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_read      (s_read),
        .s_write     (s_write),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .core_start  (core_start),
        .core_done   (core_done),
        .core_result (core_result),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (core_start === 1'b1) start_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        s_write = 1'b1; s_addr = a; s_wdata = d;
        @(posedge clk); #1;
        s_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        s_read = 1'b1; s_addr = a;
        @(posedge clk); #1;
        s_read = 1'b0;
        d = s_rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic done_pulse();
        #1 core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; s_read = 1'b0; s_write = 1'b0; core_done = 1'b0;
        s_addr = '0; s_wdata = '0; core_result = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", s_rdata, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);
        chk("rst_core_start", {31'b0, core_start}, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        rd_chk("rst_ctrl", A_CTRL, 32'h0);
        rd_chk("rst_status", A_STAT, 32'h0);
        rd_chk("rst_limit", A_LIM, 32'h0);
        rd_chk("rst_count", A_CNT, 32'h0);
        rd_chk("rst_lo0", A_LO0, 32'h0);

        // Basic run: done sampled on the 10th edge after START
        core_result = {36'h5_DEAD_BEEF, 36'hA_1234_5678};
        base = start_cnt;
        wr(A_CTRL, 32'h1);
        repeat (9) @(posedge clk);
        done_pulse();
        chk("t1_start_pulses", 32'(start_cnt - base), 32'd1);
        rd_chk("t1_lo0", A_LO0, 32'h1234_5678);
        rd_chk("t1_hi0", A_HI0, 32'h0000_000A);
        rd_chk("t1_lo1", A_LO1, 32'hDEAD_BEEF);
        rd_chk("t1_hi1", A_HI1, 32'h0000_0005);
        rd_chk("t1_status", A_STAT, 32'h2);
        rd_chk("t1_count", A_CNT, 32'd10);
        wr(A_CNT, 32'h55);
        rd_chk("ro_count", A_CNT, 32'd10);
        rd_chk("unmapped", 4'd15, 32'h0);
        rd(A_LO0, held);
        repeat (3) @(posedge clk);
        #1 chk("rdata_hold", s_rdata, held);

        // core_done while idle must not touch snapshots
        core_result = {36'h7_7777_7777, 36'h7_7777_7777};
        done_pulse();
        rd_chk("idle_done_lo0", A_LO0, 32'h1234_5678);

        // Second START during RUN, then ABORT coinciding with core_done
        wr(A_STAT, 32'h2);
        core_result = {36'hF_FFFF_FFFF, 36'h3_0000_0001};
        base = start_cnt;
        wr(A_CTRL, 32'h1);
        wr(A_CTRL, 32'h1);
        rd_chk("t2_busy", A_STAT, 32'h1);
        @(negedge clk);
        s_write = 1'b1; s_addr = A_CTRL; s_wdata = 32'h2; core_done = 1'b1;
        @(posedge clk); #1;
        s_write = 1'b0; core_done = 1'b0;
        chk("t2_start_pulses", 32'(start_cnt - base), 32'd1);
        rd_chk("t3_status", A_STAT, 32'h2);
        rd_chk("t3_lo0", A_LO0, 32'h0000_0001);
        rd_chk("t3_hi0", A_HI0, 32'h3);
        rd_chk("t3_hi1", A_HI1, 32'hF);

        // Plain ABORT: back to idle, nothing latched, DONE untouched
        wr(A_STAT, 32'h2);
        core_result = {36'h7_7777_7777, 36'h7_7777_7777};
        wr(A_CTRL, 32'h1);
        repeat (2) @(posedge clk);
        wr(A_CTRL, 32'h2);
        rd_chk("abort_status", A_STAT, 32'h0);
        rd_chk("abort_lo0", A_LO0, 32'h0000_0001);

        // W1C of DONE coinciding with completion: set wins
        wr(A_CTRL, 32'h1);
        @(negedge clk);
        s_write = 1'b1; s_addr = A_STAT; s_wdata = 32'h2; core_done = 1'b1;
        @(posedge clk); #1;
        s_write = 1'b0; core_done = 1'b0;
        rd_chk("w1c_prio_status", A_STAT, 32'h2);

        // Interrupt
        wr(A_STAT, 32'h2);
        wr(A_CTRL, 32'h4);
        rd_chk("irq_en_rd", A_CTRL, 32'h4);
        chk("irq_before", {31'b0, irq}, 32'h0);
        core_result = {36'h0_0000_0000, 36'h1_CAFE_F00D};
        wr(A_CTRL, 32'h5);
        repeat (3) @(posedge clk);
        done_pulse();
        chk("irq_set", {31'b0, irq}, 32'h1);
        wr(A_STAT, 32'h2);
        chk("irq_clr", {31'b0, irq}, 32'h0);
        rd_chk("irq_status", A_STAT, 32'h0);
        rd_chk("irq_lo0", A_LO0, 32'hCAFE_F00D);

        core_result = {36'h7_7777_7777, 36'h7_7777_7777};
`ifdef POWER_EMU_TIMEOUT_EN
        wr(A_LIM, 32'd5);
        rd_chk("to_limit_rd", A_LIM, 32'd5);
        wr(A_CTRL, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        rd_chk("to_status", A_STAT, 32'h4);
        rd_chk("to_count", A_CNT, 32'd5);
        rd_chk("to_lo0", A_LO0, 32'hCAFE_F00D);
        rd_chk("to_hi0", A_HI0, 32'h1);
        wr(A_STAT, 32'h4);
        rd_chk("to_clr", A_STAT, 32'h0);
`else
        wr(A_LIM, 32'd5);
        rd_chk("to_limit_rd", A_LIM, 32'h0);
        wr(A_CTRL, 32'h1);
        repeat (8) @(posedge clk);
        rd_chk("to_none_status", A_STAT, 32'h1);
        wr(A_CTRL, 32'h2);
        rd_chk("to_lo0", A_LO0, 32'hCAFE_F00D);
`endif

        // Reset in the middle of a run with irq pending
        wr(A_CTRL, 32'h5);
        repeat (2) @(posedge clk);
        done_pulse();
        wr(A_CTRL, 32'h5);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_irq", {31'b0, irq}, 32'h0);
        chk("mid_rst_rdata", s_rdata, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        rd_chk("mid_rst_ctrl", A_CTRL, 32'h0);
        rd_chk("mid_rst_status", A_STAT, 32'h0);
        rd_chk("mid_rst_limit", A_LIM, 32'h0);
        rd_chk("mid_rst_count", A_CNT, 32'h0);
        rd_chk("mid_rst_lo0", A_LO0, 32'h0);
        rd_chk("mid_rst_hi1", A_HI1, 32'h0);
        chk("mid_rst_irq_after", {31'b0, irq}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/power_emu_csr.md
POWER_EMU_CSR -- requirements
Module: power_emu_csr

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of emulator result channels, range 1..6.
REQ-002 SHALL have parameter RES_W, default 36: width of each channel result, range 33..64.
REQ-003 SHALL have parameter ADDR_W, default 4: word address width; 2**ADDR_W >= 4+2*N_CH.
REQ-004 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have ports s_read, input, 1 and s_write, input, 1: slave read and write strobes.
REQ-007 SHALL have ports s_addr, input, ADDR_W and s_wdata, input, 32: word address and write data.
REQ-008 SHALL have port s_rdata, output, 32: registered read data.
REQ-009 SHALL have port core_start, output, 1: one-cycle start pulse to the emulator core.
REQ-010 SHALL have port core_done, input, 1: one-cycle completion pulse from the core.
REQ-011 SHALL have port core_result, input, N_CH*RES_W: concatenated channel results, channel 0 in the LSBs.
REQ-012 SHALL have port irq, output, 1: level interrupt.

Function
REQ-013 SHALL use this map: 0 CTRL, 1 STATUS, 2 TIMEOUT_LIMIT, 3 CYCLE_COUNT, 4+2k RESULT_LO[k] = result[31:0], 5+2k RESULT_HI[k] = zero-extended result[RES_W-1:32].
REQ-014 SHALL decode CTRL as bit0 START (write-1 trigger, reads 0), bit1 ABORT (write-1 trigger, reads 0), bit2 IRQ_EN (read/write).
REQ-015 SHALL decode STATUS as bit0 BUSY (read-only), bit1 DONE (sticky, write-1-to-clear), bit2 TIMEOUT (sticky, write-1-to-clear).
REQ-016 SHALL return s_rdata one cycle after s_read; s_rdata holds its value when s_read is low; unmapped addresses read 0.
REQ-017 SHALL ignore writes to STATUS bit0, CYCLE_COUNT, RESULT registers, and unmapped addresses.
REQ-018 SHALL implement FSM states IDLE and RUN.
REQ-019 SHALL, when START is written in IDLE, enter RUN, clear CYCLE_COUNT, and assert core_start for exactly the following cycle.
REQ-020 SHALL ignore START written during RUN, with no second core_start.
REQ-021 SHALL increment CYCLE_COUNT every RUN cycle, saturating at 0xFFFFFFFF.
REQ-022 SHALL, on core_done in RUN, latch all core_result channels into RESULT snapshots, set DONE, and return to IDLE in the same edge.
REQ-023 SHALL ignore core_done in IDLE, leaving snapshots unchanged.
REQ-024 SHALL, on ABORT in RUN, return to IDLE without latching results or setting DONE.
REQ-025 SHALL give core_done priority when it coincides with an ABORT write.
REQ-026 SHALL give set priority when a W1C clear of DONE or TIMEOUT coincides with its set event.
REQ-027 SHALL drive irq = IRQ_EN & (DONE | TIMEOUT), registered.
REQ-028 SHALL update RESULT snapshots only at completion, so a multi-word read is always coherent.

Reset
REQ-029 SHALL, on reset_n low at a clock edge, set the FSM to IDLE.
REQ-030 SHALL, on that reset, clear CTRL, STATUS, CYCLE_COUNT, all RESULT snapshots, s_rdata, core_start, and irq to 0.
REQ-031 SHALL, on that reset, set TIMEOUT_LIMIT to 0.
REQ-032 SHALL, on reset during RUN, abandon the run with no latch and no flags.

Configuration
REQ-033 SHALL, with macro POWER_EMU_TIMEOUT_EN defined, make TIMEOUT_LIMIT read/write; when the limit is nonzero and CYCLE_COUNT reaches it in RUN, the block sets TIMEOUT and returns to IDLE without latching results.
REQ-034 SHALL, without POWER_EMU_TIMEOUT_EN, read TIMEOUT_LIMIT as 0, ignore writes to it, hold STATUS bit2 at 0, and never time out.

Structure
REQ-035 SHALL place register address constants, CTRL/STATUS bit positions, and the FSM state encoding in shared package power_emu_pkg.
REQ-036 SHALL isolate the FSM, CYCLE_COUNT and timeout logic in sub-module power_emu_run_ctrl; register decode and snapshots stay in the top level.

Verification
REQ-037 SHALL cover: write CTRL=1, core_done after 10 cycles with ch0 result 0xA_1234_5678 -> one core_start pulse, RESULT_LO[0]=0x12345678, RESULT_HI[0]=0xA, DONE=1, CYCLE_COUNT=10.
REQ-038 SHALL cover: START written again during RUN -> exactly one core_start, BUSY stays 1.
REQ-039 SHALL cover: ABORT written in the same cycle as core_done -> results latched, DONE=1, state IDLE.
REQ-040 SHALL cover: IRQ_EN=1 and completion -> irq=1; write STATUS=0x2 -> DONE=0 and irq=0 the next cycle.
REQ-041 SHALL cover, with POWER_EMU_TIMEOUT_EN: TIMEOUT_LIMIT=5 and no core_done -> TIMEOUT=1 after 5 RUN cycles, RESULT registers unchanged.
REQ-042 SHALL cover: reset asserted mid-RUN -> all registers read 0, BUSY=0, no irq.
